// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction loader and the main control
// decoder so both ends agree on opcodes and control-vector encodings.
//   - OP_*   : 6-bit MIPS primary opcodes
//   - CTRL_* : 9-bit main-decoder control vectors, bit order
//              {reg_write, reg_dest, alu_src, branch, dmem_write,
//               mem_to_reg, jump, alu_op[1:0]}
//   - loader_state_t : instruction loader FSM states
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [8:0] CTRL_RTYPE = 9'b110000010;
  localparam logic [8:0] CTRL_LW    = 9'b101001000;
  localparam logic [8:0] CTRL_SW    = 9'b001010000;
  localparam logic [8:0] CTRL_BEQ   = 9'b000100001;
  localparam logic [8:0] CTRL_ADDI  = 9'b101000000;
  localparam logic [8:0] CTRL_J     = 9'b000000100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

endpackage

// File: rtl/ctrl_encoder.sv
// ctrl_encoder: combinational inverse of the main control decoder. Maps a
// decoded control vector plus register/funct/immediate fields back to a
// 32-bit MIPS instruction word.
// Ports:
//   ctrl  [8:0]  control vector (see mips_pkg bit order)
//   rs, rt, rd   register fields
//   funct [5:0]  R-type function code
//   imm   [25:0] imm[15:0] for I-type, full field as J target
//   instr [31:0] encoded word (zero when not legal)
//   legal        ctrl matched one of the supported instruction classes
module ctrl_encoder
  import mips_pkg::*;
(
  input  logic [8:0]  ctrl,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = '0;
    legal = 1'b1;
    case (ctrl)
      CTRL_RTYPE: instr = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      CTRL_LW:    instr = {OP_LW,   rs, rt, imm[15:0]};
      CTRL_SW:    instr = {OP_SW,   rs, rt, imm[15:0]};
      CTRL_BEQ:   instr = {OP_BEQ,  rs, rt, imm[15:0]};
      CTRL_ADDI:  instr = {OP_ADDI, rs, rt, imm[15:0]};
      CTRL_J:     instr = {OP_J,    imm};
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: streaming instruction assembler. Each accepted control bundle
// is re-encoded into a MIPS word and written to instruction memory at
// consecutive word addresses starting from BASE_ADDR.
// Ports:
//   clk, reset (async, active high)
//   start                      begin a session from IDLE/DONE/ERROR
//   in_valid/in_ready          bundle handshake
//   in_ctrl, in_rs, in_rt, in_rd, in_funct, in_imm, in_last  bundle fields
//   imem_we/imem_addr/imem_wdata  instruction memory write port
//   busy (LOAD), done (DONE), illegal, overflow (sticky per session)
//   word_count                 words written this session
//   state                      FSM state, for observation
//
// Handshake: a bundle transfers on every rising edge where in_valid and
// in_ready are both high; in_valid may be raised at any time and the bundle
// fields must be held stable until that edge. in_ready never depends on
// in_valid.
module instr_loader
  import mips_pkg::*;
#(
  parameter int IMEM_ADDR_W = 6,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8:0]             in_ctrl,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [5:0]             in_funct,
  input  logic [25:0]            in_imm,
  input  logic                   in_last,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic                   overflow,
  output logic [IMEM_ADDR_W:0]   word_count,
  output loader_state_t          state
);

  localparam int DEPTH = 2 ** IMEM_ADDR_W;
  localparam logic [IMEM_ADDR_W:0]   DEPTH_CNT = (IMEM_ADDR_W + 1)'(DEPTH);
  localparam logic [IMEM_ADDR_W-1:0] BASE_PTR  = IMEM_ADDR_W'(BASE_ADDR);

  loader_state_t state_q, state_d;

  // Write stage: holds one encoded word between acceptance and the memory write.
  logic                   wr_pend;
  logic                   wr_last;
  logic [31:0]            wr_data;
  logic [IMEM_ADDR_W-1:0] ptr;
  logic [IMEM_ADDR_W:0]   wc;
  logic                   illegal_q;
  logic                   overflow_q;

  logic [31:0]            enc_instr;
  logic                   enc_legal;
  logic [IMEM_ADDR_W:0]   occupancy;
  logic                   accept;
  logic                   accept_bad;
  logic                   start_ok;
  logic                   write_fills;

  ctrl_encoder u_enc (
    .ctrl  (in_ctrl),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .funct (in_funct),
    .imm   (in_imm),
    .instr (enc_instr),
    .legal (enc_legal)
  );

  // Count the word still sitting in the write stage so that back-to-back
  // traffic cannot accept one beat more than memory can hold. Once the last
  // beat is in flight no further beat may slip in before the move to DONE.
  assign occupancy   = wc + {{IMEM_ADDR_W{1'b0}}, wr_pend};
  assign in_ready    = (state_q == ST_LOAD) && !(wr_pend && wr_last) &&
                       (occupancy < DEPTH_CNT);
  assign accept      = in_valid && in_ready;
  assign accept_bad  = accept && !enc_legal;
  assign start_ok    = start && (state_q != ST_LOAD);
  assign write_fills = wr_pend && (wc == DEPTH_CNT - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Illegal input outranks a completing last write; a last write
        // filling the final slot is a clean finish, not an overflow.
        if (accept_bad)              state_d = ST_ERROR;
        else if (wr_pend && wr_last) state_d = ST_DONE;
        else if (write_fills)        state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend    <= 1'b0;
      wr_last    <= 1'b0;
      wr_data    <= '0;
      ptr        <= BASE_PTR;
      wc         <= '0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // Illegal beats are consumed without entering the write stage.
      wr_pend <= accept && enc_legal;
      if (accept && enc_legal) begin
        wr_data <= enc_instr;
        wr_last <= in_last;
      end

      if (start_ok) begin
        ptr        <= BASE_PTR;
        wc         <= '0;
        illegal_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        // A write in flight when the FSM leaves LOAD still completes and counts.
        if (wr_pend) begin
          ptr <= ptr + 1'b1;
          wc  <= wc + 1'b1;
        end
        if (accept_bad) illegal_q <= 1'b1;
        if ((state_q == ST_LOAD) && write_fills && !wr_last && !accept_bad)
          overflow_q <= 1'b1;
      end
    end
  end

  assign imem_we    = wr_pend;
  assign imem_addr  = ptr;
  assign imem_wdata = wr_data;
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);
  assign illegal    = illegal_q;
  assign overflow   = overflow_q;
  assign word_count = wc;
  assign state      = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader. Three instances share clock, reset and bundle
// inputs; each has its own start so only the selected one takes part:
//   0: IMEM_ADDR_W=6, BASE_ADDR=0   1: IMEM_ADDR_W=2, BASE_ADDR=0
//   2: IMEM_ADDR_W=6, BASE_ADDR=62
// Expected writes {cycle, addr, word} are queued when a beat handshakes and
// popped by a monitor when the selected instance writes.
module tb_instr_loader;
  import mips_pkg::*;

  localparam logic [8:0] C_R    = 9'b110000010;
  localparam logic [8:0] C_LW   = 9'b101001000;
  localparam logic [8:0] C_SW   = 9'b001010000;
  localparam logic [8:0] C_BEQ  = 9'b000100001;
  localparam logic [8:0] C_ADDI = 9'b101000000;
  localparam logic [8:0] C_J    = 9'b000000100;
  localparam logic [8:0] C_BAD  = 9'b111111111;

  logic        clk;
  logic        reset;
  logic [2:0]  start_v;
  logic        in_valid;
  logic [8:0]  in_ctrl;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [25:0] in_imm;
  logic        in_last;

  logic          we_a[3], rdy_a[3], busy_a[3], done_a[3], ill_a[3], ovf_a[3];
  logic [6:0]    addr_a[3], wc_a[3];
  logic [31:0]   wdata_a[3];
  loader_state_t st_a[3];

  logic [5:0] addr0, addr2;
  logic [1:0] addr1;
  logic [2:0] wc1;

  int sel = 0;
  int checks = 0;
  int errors = 0;
  int pos_cyc = 0;
  int cur_run = 0;
  int max_run = 0;
  logic [6:0] exp_ptr;
  logic [6:0] exp_mask;
  logic [54:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pos_cyc <= pos_cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  instr_loader #(.IMEM_ADDR_W(6), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy_a[0]),
    .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_a[0]), .imem_addr(addr0),
    .imem_wdata(wdata_a[0]), .busy(busy_a[0]), .done(done_a[0]), .illegal(ill_a[0]),
    .overflow(ovf_a[0]), .word_count(wc_a[0]), .state(st_a[0])
  );

  instr_loader #(.IMEM_ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy_a[1]),
    .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_a[1]), .imem_addr(addr1),
    .imem_wdata(wdata_a[1]), .busy(busy_a[1]), .done(done_a[1]), .illegal(ill_a[1]),
    .overflow(ovf_a[1]), .word_count(wc1), .state(st_a[1])
  );

  instr_loader #(.IMEM_ADDR_W(6), .BASE_ADDR(62)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy_a[2]),
    .in_ctrl(in_ctrl), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_a[2]), .imem_addr(addr2),
    .imem_wdata(wdata_a[2]), .busy(busy_a[2]), .done(done_a[2]), .illegal(ill_a[2]),
    .overflow(ovf_a[2]), .word_count(wc_a[2]), .state(st_a[2])
  );

  assign addr_a[0] = {1'b0, addr0};
  assign addr_a[1] = {5'b00000, addr1};
  assign addr_a[2] = {1'b0, addr2};
  assign wc_a[1]   = {4'b0000, wc1};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every write of the selected instance must match the
  // head of the expected queue in cycle, address and data.
  always @(negedge clk) begin
    logic [54:0] e;
    if (we_a[sel] === 1'b1) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (exp_q.size() == 0) begin
        check("extra_write_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", 64'(pos_cyc[15:0]), 64'(e[54:39]));
        check("wr_addr",  64'(addr_a[sel]),   64'(e[38:32]));
        check("wr_data",  64'(wdata_a[sel]),  64'(e[31:0]));
      end
    end else begin
      cur_run = 0;
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic do_start(input int s, input logic [6:0] base, input logic [6:0] mask);
    sel      = s;
    exp_ptr  = base;
    exp_mask = mask;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // Presents one bundle and waits (bounded) for its handshake. in_valid is
  // left high so consecutive calls stream without bubbles.
  task automatic send_beat(input string tag, input logic [8:0] ctrl,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [5:0] funct, input logic [25:0] imm, input logic last,
                           input logic writes, input logic [31:0] exp_word,
                           input logic exp_acc);
    int   waited = 0;
    logic got    = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = ctrl;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_funct = funct;
    in_imm   = imm;
    in_last  = last;
    while ((rdy_a[sel] !== 1'b1) && (waited < 6)) begin
      @(negedge clk);
      waited++;
    end
    if (rdy_a[sel] === 1'b1) begin
      got = 1'b1;
      if (writes) begin
        exp_q.push_back({16'(pos_cyc + 1), exp_ptr, exp_word});
        exp_ptr = (exp_ptr + 7'd1) & exp_mask;
      end
      @(negedge clk);
    end
    check({"accept_", tag}, 64'(got), 64'(exp_acc));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; start_v = '0; in_valid = 1'b0; in_ctrl = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0; in_last = 1'b0;
    exp_ptr = '0; exp_mask = 7'd63;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_we",       64'(we_a[0]),   64'd0);
    check("rst_addr",     64'(addr_a[0]), 64'd0);
    check("rst_addr_b62", 64'(addr_a[2]), 64'd62);
    check("rst_busy",     64'(busy_a[0]), 64'd0);
    check("rst_done",     64'(done_a[0]), 64'd0);
    check("rst_illegal",  64'(ill_a[0]),  64'd0);
    check("rst_overflow", 64'(ovf_a[0]),  64'd0);
    check("rst_wc",       64'(wc_a[0]),   64'd0);
    check("rst_ready",    64'(rdy_a[0]),  64'd0);
    check("rst_state",    64'(st_a[0]),   64'(ST_IDLE));
    reset = 1'b0;

    // Valid while idle is ignored
    in_valid = 1'b1; in_ctrl = C_ADDI; in_imm = 26'd7;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(rdy_a[0]), 64'd0);
    check("idle_state", 64'(st_a[0]),  64'(ST_IDLE));
    idle(1);

    // Six back-to-back beats, J carries in_last
    max_run = 0;
    do_start(0, 7'd0, 7'd63);
    check("load_busy",  64'(busy_a[0]), 64'd1);
    check("load_ready", 64'(rdy_a[0]),  64'd1);
    send_beat("addi", C_ADDI, 5'd0, 5'd2, 5'd0, 6'd0, 26'h0005, 1'b0, 1'b1, 32'h20020005, 1'b1);
    send_beat("lw",   C_LW,   5'd0, 5'd3, 5'd0, 6'd0, 26'h0044, 1'b0, 1'b1, 32'h8C030044, 1'b1);
    send_beat("sw",   C_SW,   5'd0, 5'd3, 5'd0, 6'd0, 26'h0048, 1'b0, 1'b1, 32'hAC030048, 1'b1);
    send_beat("beq",  C_BEQ,  5'd2, 5'd3, 5'd0, 6'd0, 26'hFFFF, 1'b0, 1'b1, 32'h1043FFFF, 1'b1);
    send_beat("add",  C_R,    5'd2, 5'd3, 5'd4, 6'h20, 26'h0,   1'b0, 1'b1, 32'h00432020, 1'b1);
    send_beat("j",    C_J,    5'd0, 5'd0, 5'd0, 6'd0, 26'h11,   1'b1, 1'b1, 32'h08000011, 1'b1);
    idle(2);
    check("t1_done",    64'(done_a[0]), 64'd1);
    check("t1_wc",      64'(wc_a[0]),   64'd6);
    check("t1_state",   64'(st_a[0]),   64'(ST_DONE));
    check("t1_ready",   64'(rdy_a[0]),  64'd0);
    check("t1_we_run",  64'(max_run),   64'd6);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Illegal second beat while the first write is in flight
    do_start(0, 7'd0, 7'd63);
    send_beat("ill_b1", C_ADDI, 5'd1, 5'd1, 5'd0, 6'd0, 26'h1, 1'b0, 1'b1, 32'h20210001, 1'b1);
    send_beat("ill_b2", C_BAD,  5'd1, 5'd1, 5'd0, 6'd0, 26'h1, 1'b0, 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    check("ill_flag",  64'(ill_a[0]), 64'd1);
    check("ill_state", 64'(st_a[0]),  64'(ST_ERROR));
    check("ill_ready", 64'(rdy_a[0]), 64'd0);
    check("ill_wc",    64'(wc_a[0]),  64'd1);
    send_beat("ill_b3", C_ADDI, 5'd1, 5'd1, 5'd0, 6'd0, 26'h1, 1'b0, 1'b1, 32'h20210001, 1'b0);
    idle(1);
    do_start(0, 7'd0, 7'd63);
    check("restart_state", 64'(st_a[0]),  64'(ST_LOAD));
    check("restart_ill",   64'(ill_a[0]), 64'd0);
    check("restart_wc",    64'(wc_a[0]),  64'd0);
    send_beat("restart_sw", C_SW, 5'd5, 5'd6, 5'd0, 6'd0, 26'h10, 1'b1, 1'b1, 32'hACA60010, 1'b1);
    idle(2);
    check("restart_done", 64'(done_a[0]), 64'd1);

    // Overflow on a 4-word memory
    do_start(1, 7'd0, 7'd3);
    send_beat("of1", C_ADDI, 5'd0, 5'd1, 5'd0, 6'd0, 26'h1, 1'b0, 1'b1, 32'h20010001, 1'b1);
    send_beat("of2", C_ADDI, 5'd0, 5'd2, 5'd0, 6'd0, 26'h2, 1'b0, 1'b1, 32'h20020002, 1'b1);
    send_beat("of3", C_ADDI, 5'd0, 5'd3, 5'd0, 6'd0, 26'h3, 1'b0, 1'b1, 32'h20030003, 1'b1);
    send_beat("of4", C_ADDI, 5'd0, 5'd4, 5'd0, 6'd0, 26'h4, 1'b0, 1'b1, 32'h20040004, 1'b1);
    send_beat("of5", C_ADDI, 5'd0, 5'd5, 5'd0, 6'd0, 26'h5, 1'b0, 1'b1, 32'h20050005, 1'b0);
    idle(1);
    check("of_flag",  64'(ovf_a[1]), 64'd1);
    check("of_state", 64'(st_a[1]),  64'(ST_ERROR));
    check("of_wc",    64'(wc_a[1]),  64'd4);
    check("of_ill",   64'(ill_a[1]), 64'd0);
    do_start(1, 7'd0, 7'd3);
    check("of_clear", 64'(ovf_a[1]), 64'd0);
    send_beat("fl1", C_ADDI, 5'd0, 5'd5, 5'd0, 6'd0, 26'h5, 1'b0, 1'b1, 32'h20050005, 1'b1);
    send_beat("fl2", C_ADDI, 5'd0, 5'd6, 5'd0, 6'd0, 26'h6, 1'b0, 1'b1, 32'h20060006, 1'b1);
    send_beat("fl3", C_ADDI, 5'd0, 5'd7, 5'd0, 6'd0, 26'h7, 1'b0, 1'b1, 32'h20070007, 1'b1);
    send_beat("fl4", C_ADDI, 5'd0, 5'd8, 5'd0, 6'd0, 26'h8, 1'b1, 1'b1, 32'h20080008, 1'b1);
    idle(2);
    check("full_done",  64'(done_a[1]), 64'd1);
    check("full_ovf",   64'(ovf_a[1]),  64'd0);
    check("full_wc",    64'(wc_a[1]),   64'd4);
    check("full_state", 64'(st_a[1]),   64'(ST_DONE));

    // Reset while an accepted beat sits in the write stage
    do_start(0, 7'd0, 7'd63);
    send_beat("rs_b1", C_ADDI, 5'd0, 5'd9, 5'd0, 6'd0, 26'h9, 1'b0, 1'b1, 32'h20090009, 1'b1);
    in_ctrl = C_LW; in_rs = 5'd1; in_rt = 5'd2; in_imm = 26'h4; in_last = 1'b0;
    check("rs_ready_before", 64'(rdy_a[0]), 64'd1);
    @(posedge clk);
    #1;
    check("rs_we_pending", 64'(we_a[0]), 64'd1);
    reset = 1'b1;
    #1;
    check("rs_we_killed", 64'(we_a[0]), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rs_state", 64'(st_a[0]), 64'(ST_IDLE));
    check("rs_wc",    64'(wc_a[0]), 64'd0);
    idle(1);
    do_start(0, 7'd0, 7'd63);
    send_beat("rs_j", C_J, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF, 1'b1, 1'b1, 32'h0BFFFFFF, 1'b1);
    idle(2);
    check("rs_done", 64'(done_a[0]), 64'd1);
    check("rs_wc1",  64'(wc_a[0]),   64'd1);

    // Pointer wrap from BASE_ADDR=62; start while loading is ignored
    do_start(2, 7'd62, 7'd63);
    send_beat("wr1", C_BEQ, 5'd1, 5'd2, 5'd0, 6'd0, 26'h3, 1'b0, 1'b1, 32'h10220003, 1'b1);
    idle(1);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    check("start_in_load_wc",    64'(wc_a[2]), 64'd1);
    check("start_in_load_state", 64'(st_a[2]), 64'(ST_LOAD));
    send_beat("wr2", C_R,  5'd5,  5'd6, 5'd7, 6'h22, 26'h0,    1'b0, 1'b1, 32'h00A63822, 1'b1);
    send_beat("wr3", C_LW, 5'd31, 5'd1, 5'd0, 6'd0,  26'h8000, 1'b1, 1'b1, 32'h8FE18000, 1'b1);
    idle(2);
    check("wrap_wc",    64'(wc_a[2]),   64'd3);
    check("wrap_done",  64'(done_a[2]), 64'd1);
    check("wrap_addr",  64'(addr_a[2]), 64'd1);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Streaming instruction assembler and loader, the inverse of the main control decoder.
- Accepts one decoded control bundle per handshake: the 9 main-decoder control bits plus register, funct and immediate fields.
- Re-encodes each bundle into a 32-bit MIPS word (R-type, LW, SW, BEQ, ADDI, J) and writes it into instruction memory at consecutive word addresses.
- Used by test infrastructure and boot logic to load imem before the pipelined core runs.

Parameters:
- IMEM_ADDR_W, 6, imem word-address width; DEPTH = 2**IMEM_ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a load session from IDLE, DONE or ERROR.
- in_valid  input  1  bundle valid.
- in_ready  output  1  bundle accepted on a cycle where in_valid & in_ready.
- in_ctrl  input  9  {reg_write, reg_dest, alu_src, branch, dmem_write, mem_to_reg, jump, alu_op[1:0]}.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_funct  input  6  R-type funct.
- in_imm  input  26  imm[15:0] for I-type; full 26 bits as J target.
- in_last  input  1  marks final bundle of the session.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  IMEM_ADDR_W  write word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- illegal  output  1  sticky; unrecognised in_ctrl pattern.
- overflow  output  1  sticky; imem filled before in_last.
- word_count  output  IMEM_ADDR_W+1  words written this session.

Behaviour:
- Reset (async): state = IDLE, all outputs 0, imem_addr = BASE_ADDR, pending write stage cleared. Reset mid-session aborts it; no partial write is issued after reset.
- FSM states: IDLE, LOAD, DONE, ERROR.
- in_ready = (state == LOAD) & (word_count < DEPTH).
- start in IDLE, DONE or ERROR: go to LOAD, clear illegal, overflow and word_count, set the address pointer to BASE_ADDR. start is ignored in LOAD.
- Encoding, by in_ctrl value:
  - 110000010 -> op 000000, word {op, rs, rt, rd, 5'b0, funct}.
  - 101001000 -> LW 100011, word {op, rs, rt, imm[15:0]}.
  - 001010000 -> SW 101011, same I-type layout.
  - 000100001 -> BEQ 000100, same I-type layout.
  - 101000000 -> ADDI 001000, same I-type layout.
  - 000000100 -> J 000010, word {op, imm[25:0]}.
  - Any other value is illegal.
- Latency: a legal beat accepted at edge N produces imem_we = 1 for exactly one cycle after edge N+1, with imem_addr = current pointer and imem_wdata = encoded word. The pointer and word_count increment at the same edge the write completes.
- Accepted beats are written back-to-back, one per cycle, with no bubbles.
- Pointer wraps modulo DEPTH from BASE_ADDR. Overflow is detected through word_count, not the pointer.
- Illegal beat: accepted (consumed) but not written. illegal = 1, next state ERROR, in_ready = 0 from the following cycle. A legal write already in flight still completes.
- in_last on a legal beat: after its write, state = DONE and done = 1 until start.
- in_last on an illegal beat: ERROR takes priority over DONE.
- Overflow: when word_count reaches DEPTH without in_last having been accepted, set overflow = 1 and go to ERROR.
- A beat carrying in_last that fills the last slot goes to DONE, not ERROR.
- in_valid while not in LOAD is ignored, since in_ready = 0.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the 9-bit control-vector constants, shared with the main decoder so both ends agree;
  - the loader state enum.
- Sub-module ctrl_encoder (combinational): maps in_ctrl plus fields to {instr[31:0], legal}.
- instr_loader holds the FSM, the write stage register and the counters.

Test Plan:
- Load 6 beats (ADDI rs=0 rt=2 imm=5; LW rs=0 rt=3 imm=0x44; SW; BEQ imm=0xFFFF; R-type add rs=2 rt=3 rd=4 funct=0x20; J imm=0x11, in_last) -> writes at addrs 0..5, including 0x20020005, 0x8C030044, 0x00432020, 0x08000011; done=1, word_count=6.
- Hold in_valid continuously -> imem_we high on 6 consecutive cycles; each write lands one cycle after its handshake.
- in_ctrl = 9'b111111111 as beat 2 -> only beat 1 written; illegal=1; state ERROR; in_ready=0; start then returns to LOAD with flags cleared.
- IMEM_ADDR_W=2, 5 beats without in_last -> 4 writes; overflow=1; 5th beat never accepted. A separate run with in_last on beat 4 -> done=1, overflow=0.
- Assert reset mid-session on a handshake cycle -> imem_we=0 immediately; no write for that beat; after start, the first write goes to BASE_ADDR.
- BASE_ADDR=62, IMEM_ADDR_W=6, 3 beats -> writes at addrs 62, 63, 0; word_count=3.
